// File: rtl/time_display_scan.sv
// time_display_scan
// Snapshots the binary sec/min/hour bus once per display frame and converts
// each field to two BCD digits. It then scans six active-low 7-segment digits
// (HH:MM:SS) with a blanking gap at the start of every digit slot.
// Optional build macro: DISP_12H_EN selects a 12-hour display with a PM dot
// on digit 5. When the macro is undefined the display is 24-hour.
module time_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_tick,
  output logic       range_err
);

  localparam int            PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  logic [PW-1:0] pcnt_r, pcnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [5:0]    sec_r, min_r;
  logic [4:0]    hour_r;
  logic          snap_s, bad_s, range_v_s;
  logic [5:0]    sec_v_s, min_v_s;
  logic [4:0]    hour_v_s, hour_disp_s;
  logic [3:0]    digit_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic [5:0]    an_s;

  // Slot counter / digit index advance; disable parks the scan at digit 0
  always_comb begin
    pcnt_s = pcnt_r;
    idx_s  = idx_r;
    if (!disp_en) begin
      pcnt_s = {PW{1'b0}};
      idx_s  = 3'd0;
    end else if (pcnt_r == PCNT_LAST) begin
      pcnt_s = {PW{1'b0}};
      idx_s  = (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
    end else begin
      pcnt_s = pcnt_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Frame snapshot: during the snapshot cycle the live bus is used directly
  always_comb begin
    snap_s = disp_en & (pcnt_r == {PW{1'b0}}) & (idx_r == 3'd0);
    bad_s  = (sec > 6'd59) | (min > 6'd59) | (hour > 5'd23);
    if (snap_s) begin
      sec_v_s   = sec;
      min_v_s   = min;
      hour_v_s  = hour;
      range_v_s = bad_s;
    end else begin
      sec_v_s   = sec_r;
      min_v_s   = min_r;
      hour_v_s  = hour_r;
      range_v_s = range_err;
    end
  end

  // Hour value as shown on the display
  always_comb begin
`ifdef DISP_12H_EN
    if (hour_v_s == 5'd0) begin
      hour_disp_s = 5'd12;
    end else if (hour_v_s > 5'd12) begin
      hour_disp_s = hour_v_s - 5'd12;
    end else begin
      hour_disp_s = hour_v_s;
    end
`else
    hour_disp_s = hour_v_s;
`endif
  end

  // BCD digit for the slot being scanned
  always_comb begin
    case (idx_r)
      3'd0:    digit_s = 4'(sec_v_s % 6'd10);
      3'd1:    digit_s = 4'(sec_v_s / 6'd10);
      3'd2:    digit_s = 4'(min_v_s % 6'd10);
      3'd3:    digit_s = 4'(min_v_s / 6'd10);
      3'd4:    digit_s = 4'(hour_disp_s % 5'd10);
      3'd5:    digit_s = 4'(hour_disp_s / 5'd10);
      default: digit_s = 4'd0;
    endcase
  end

  // Next display pins: blank gap first, then exactly one anode low
  always_comb begin
    seg_s = 7'h7F;
    dp_s  = 1'b1;
    an_s  = 6'h3F;
    if (disp_en && (pcnt_r >= BLANK_END)) begin
      an_s  = ~(6'b000001 << idx_r);
      seg_s = range_v_s ? 7'b0111111 : seg_code(digit_s);
      dp_s  = ((idx_r == 3'd2) || (idx_r == 3'd4)) ? 1'b0 : 1'b1;
`ifdef DISP_12H_EN
      // Leading hour zero is suppressed; the slot stays lit only for the PM dot
      if ((idx_r == 3'd5) && !range_v_s && (hour_disp_s < 5'd10)) begin
        seg_s = 7'h7F;
        if (hour_v_s >= 5'd12) begin
          dp_s = 1'b0;
        end else begin
          an_s = 6'h3F;
        end
      end else begin
        if ((idx_r == 3'd5) && !range_v_s && (hour_v_s >= 5'd12)) begin
          dp_s = 1'b0;
        end else begin
          dp_s = dp_s;
        end
      end
`endif
    end else begin
      an_s = 6'h3F;
    end
  end

  // Scan state, snapshot registers and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r     <= {PW{1'b0}};
      idx_r      <= 3'd0;
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hour_r     <= 5'd0;
      range_err  <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= 6'h3F;
    end else begin
      pcnt_r     <= pcnt_s;
      idx_r      <= idx_s;
      sec_r      <= sec_v_s;
      min_r      <= min_v_s;
      hour_r     <= hour_v_s;
      range_err  <= range_v_s;
      frame_tick <= snap_s;
      seg        <= seg_s;
      dp         <= dp_s;
      an         <= an_s;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan (REFRESH_DIV=8, BLANK_CYC=2).
// Build with DISP_12H_EN defined to exercise the 12-hour display.
module tb_time_display_scan;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = 6 * RD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] sec = 6'd0, min = 6'd0;
  logic [4:0] hour = 5'd0;
  logic       disp_en = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_tick, range_err;

  time_display_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .sec(sec), .min(min), .hour(hour),
    .disp_en(disp_en), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: position in frame plus the captured time
  int         c = 0;
  int         ms = 0, mm = 0, mh = 0;
  bit         mr = 1'b0;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic [5:0] e_an = 6'h3F;
  logic       e_ft = 1'b0, e_re = 1'b0;

  typedef struct {
    logic [5:0]      s;
    logic [5:0]      m;
    logic [4:0]      h;
    logic [5:0][6:0] sg;   // expected code per slot, index = slot
    logic            re;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_edge();
    int  s, hd, dig;
    bit  take;
    if (!rst_n) begin
      c = 0; ms = 0; mm = 0; mh = 0; mr = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 6'h3F; e_ft = 1'b0; e_re = 1'b0;
      return;
    end
    take = disp_en && (c == 0);
    if (take) begin
      ms = sec; mm = min; mh = hour;
      mr = (sec > 59) || (min > 59) || (hour > 23);
    end
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 6'h3F; e_ft = take; e_re = mr;
    if (disp_en && ((c % RD) >= BL)) begin
      s  = c / RD;
      hd = mh;
`ifdef DISP_12H_EN
      hd = (mh == 0) ? 12 : ((mh > 12) ? mh - 12 : mh);
`endif
      case (s)
        0: dig = ms % 10;
        1: dig = ms / 10;
        2: dig = mm % 10;
        3: dig = mm / 10;
        4: dig = hd % 10;
        default: dig = hd / 10;
      endcase
      e_an[s] = 1'b0;
      e_seg = mr ? 7'b0111111 : code7(dig);
      e_dp = (s == 2 || s == 4) ? 1'b0 : 1'b1;
`ifdef DISP_12H_EN
      if (s == 5 && !mr && mh >= 12) e_dp = 1'b0;
      if (s == 5 && !mr && hd < 10) begin
        e_seg = 7'h7F;
        if (mh < 12) e_an = 6'h3F;
      end
`endif
    end
    c = disp_en ? (c + 1) % FR : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("outputs", {16'd0, seg, dp, an, frame_tick, range_err},
        {16'd0, e_seg, e_dp, e_an, e_ft, e_re});
    chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FR && !seen; i++) begin
      step();
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t1, t2;
    // {sec,min,hour, {slot5..slot0}, range_err}
    tbl[0] = '{6'd56, 6'd34, 5'd12, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0};
`ifdef DISP_12H_EN
    tbl[1] = '{6'd0, 6'd0, 5'd0, {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[2] = '{6'd59, 6'd59, 5'd23, {7'h79, 7'h79, 7'h12, 7'h10, 7'h12, 7'h10}, 1'b0};
    tbl[3] = '{6'd8, 6'd7, 5'd9, {7'h7F, 7'h10, 7'h40, 7'h78, 7'h40, 7'h00}, 1'b0};
    tbl[4] = '{6'd0, 6'd0, 5'd13, {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[8] = '{6'd0, 6'd0, 5'd0, {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
`else
    tbl[1] = '{6'd0, 6'd0, 5'd0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[2] = '{6'd59, 6'd59, 5'd23, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 1'b0};
    tbl[3] = '{6'd8, 6'd7, 5'd9, {7'h40, 7'h10, 7'h40, 7'h78, 7'h40, 7'h00}, 1'b0};
    tbl[4] = '{6'd0, 6'd0, 5'd13, {7'h79, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[8] = '{6'd0, 6'd0, 5'd0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
`endif
    tbl[5] = '{6'd60, 6'd0, 5'd0, {6{7'h3F}}, 1'b1};
    tbl[6] = '{6'd5, 6'd63, 5'd5, {6{7'h3F}}, 1'b1};
    tbl[7] = '{6'd0, 6'd0, 5'd24, {6{7'h3F}}, 1'b1};

    // reset state
    sec = 6'd56; min = 6'd34; hour = 5'd12;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_an", {26'd0, an}, 32'h3F);
    chk("reset_dp_ft_re", {29'd0, dp, frame_tick, range_err}, 32'h4);
    repeat (2) step();
    rst_n = 1'b1;
    disp_en = 1'b1;

    // frame period
    t1 = -1; t2 = -1;
    for (int i = 0; i < 120 && t2 < 0; i++) begin
      step();
      if (frame_tick) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    chk("tick_period", t2 - t1, FR);

    // table of times: check every slot's digit code near the end of its slot
    for (int i = 0; i < 9; i++) begin
      sec = tbl[i].s; min = tbl[i].m; hour = tbl[i].h;
      wait_tick();
      for (int j = 1; j < FR; j++) begin
        step();
        if (j % RD == RD - 1) begin
          chk($sformatf("tbl%0d_slot%0d_seg", i, j / RD), {25'd0, seg}, {25'd0, tbl[i].sg[j / RD]});
          if (j / RD < 5)
            chk($sformatf("tbl%0d_slot%0d_dp", i, j / RD), {31'd0, dp},
                {31'd0, !((j / RD) == 2 || (j / RD) == 4)});
        end
      end
      chk($sformatf("tbl%0d_range_err", i), {31'd0, range_err}, {31'd0, tbl[i].re});
    end

    // mid-frame change is held until the next snapshot
    sec = 6'd56; min = 6'd34; hour = 5'd12;
    wait_tick();
    wait_tick();
    repeat (3) step();
    sec = 6'd57;
    repeat (2) step();
    chk("hold_slot0", {25'd0, seg}, 32'h02);
    repeat (42) step();
    wait_tick();
    repeat (7) step();
    chk("new_slot0", {25'd0, seg}, 32'h78);

    // drop enable during slot 3, then re-raise
    wait_tick();
    repeat (28) step();
    chk("slot3_an", {26'd0, an}, 32'h37);
    disp_en = 1'b0;
    step();
    chk("dis_an", {26'd0, an}, 32'h3F);
    chk("dis_seg", {25'd0, seg}, 32'h7F);
    repeat (3) step();
    disp_en = 1'b1;
    step();
    chk("reen_tick", {31'd0, frame_tick}, 32'd1);
    repeat (2) step();
    chk("reen_slot0_an", {26'd0, an}, 32'h3E);

    // asynchronous reset mid-slot
    wait_tick();
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_an", {26'd0, an}, 32'h3F);
    chk("async_dp", {31'd0, dp}, 32'd1);
    model_edge();
    repeat (2) step();
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          sec = 6'($urandom_range(0, 63));
          min = 6'($urandom_range(0, 63));
          hour = 5'($urandom_range(0, 31));
        end else begin
          sec = 6'($urandom_range(0, 59));
          min = 6'($urandom_range(0, 59));
          hour = 5'($urandom_range(0, 23));
        end
      end
      if ($urandom_range(0, 149) == 0) disp_en = ~disp_en;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
